div_seq_ctrl: RTL and testbench

DIV_SEQ_CTRL -- requirements
Module: div_seq_ctrl

---
 rtl/div_seq_ctrl.sv | 118 +++++++++++
 tb/tb_div_seq_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq_ctrl.sv
// Sequential 32-bit integer divider controller for the EX stage.
// Restoring radix-2 divide, 32 steps, signed and unsigned, zero-divisor shortcut.
module div_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] opa_i,
    input  logic [31:0] opb_i,
    input  logic        cancel_i,
    output logic        stall_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        hilo_we_o,
    output logic        div0_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [63:0] remQuot;
    logic [31:0] divMag;
    logic        negQ;
    logic        negR;

    logic        accept;
    logic [31:0] opaMag;
    logic [31:0] opbMag;
    logic        fits;
    logic [31:0] diff;
    logic [63:0] stepVal;
    logic [31:0] qAbs;
    logic [31:0] rAbs;

    always_comb begin
        accept = (state == IDLE) & start_i & ~cancel_i;
        opaMag = (signed_i & opa_i[31]) ? -opa_i : opa_i;
        opbMag = (signed_i & opb_i[31]) ? -opb_i : opb_i;
        // 33-bit partial remainder after the shift; the difference fits in 32 bits
        fits = remQuot[63:31] >= {1'b0, divMag};
        diff = remQuot[62:31] - divMag;
        if (fits) begin
            stepVal = {diff, remQuot[30:0], 1'b1};
        end else begin
            stepVal = {remQuot[62:0], 1'b0};
        end
        qAbs = stepVal[31:0];
        rAbs = stepVal[63:32];
    end

    assign stall_o = ((state == IDLE) & start_i & ~cancel_i)
                   | ((state == CALC) & ~cancel_i);
    assign busy_o    = state != IDLE;
    assign done_o    = (state == DONE) & ~cancel_i;
    assign hilo_we_o = (state == DONE) & ~cancel_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            remQuot <= '0;
            divMag  <= '0;
            negQ    <= 1'b0;
            negR    <= 1'b0;
            div0_o  <= 1'b0;
            hi_o    <= '0;
            lo_o    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        negQ    <= signed_i & (opa_i[31] ^ opb_i[31]);
                        negR    <= signed_i & opa_i[31];
                        divMag  <= opbMag;
                        remQuot <= {32'd0, opaMag};
                        cnt     <= '0;
                        if (opb_i == 32'd0) begin
                            state  <= DONE;
                            hi_o   <= opa_i;
                            lo_o   <= '1;
                            div0_o <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (cancel_i) begin
                        state <= IDLE;
                    end else begin
                        remQuot <= stepVal;
                        cnt     <= cnt + 6'd1;
                        if (cnt == 6'd31) begin
                            state  <= DONE;
                            lo_o   <= negQ ? -qAbs : qAbs;
                            hi_o   <= negR ? -rAbs : rAbs;
                            div0_o <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: latency, signed/unsigned results,
// zero divisor, cancel in CALC/DONE/IDLE, reset mid-operation.
module tb_div_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] opa_i;
    logic [31:0] opb_i;
    logic        cancel_i;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic        hilo_we_o;
    logic        div0_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int nVec = 0;
    int nErr = 0;

    div_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .signed_i  (signed_i),
        .opa_i     (opa_i),
        .opb_i     (opb_i),
        .cancel_i  (cancel_i),
        .stall_o   (stall_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .hilo_we_o (hilo_we_o),
        .div0_o    (div0_o),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // inputs change 2 time units after the rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // outputs are sampled on the falling edge
    task automatic settle();
        #3;
    endtask

    task automatic doOp(input logic [31:0] a, input logic [31:0] b,
                        input logic s, input int lat,
                        input logic [31:0] expLo, input logic [31:0] expHi,
                        input logic expDz);
        tick();
        start_i  = 1'b1;
        opa_i    = a;
        opb_i    = b;
        signed_i = s;
        cancel_i = 1'b0;
        settle();
        chk("accept_busy", busy_o, 0);
        chk("accept_stall", stall_o, 1);
        tick();
        start_i  = 1'b0;
        opa_i    = ~a;
        opb_i    = b + 32'd1;
        signed_i = ~s;
        settle();
        for (int i = 1; i < lat; i++) begin
            chk("calc_stall", stall_o, 1);
            chk("calc_done", done_o, 0);
            tick();
            settle();
        end
        chk("done", done_o, 1);
        chk("hilo_we", hilo_we_o, 1);
        chk("done_stall", stall_o, 0);
        chk("done_busy", busy_o, 1);
        chk("lo", lo_o, expLo);
        chk("hi", hi_o, expHi);
        chk("div0", div0_o, expDz);
    endtask

    initial begin
        rst      = 1'b0;
        start_i  = 1'b0;
        signed_i = 1'b0;
        opa_i    = '0;
        opb_i    = '0;
        cancel_i = 1'b0;
        #8;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_hilo_we", hilo_we_o, 0);
        chk("rst_div0", div0_o, 0);
        chk("rst_hi", hi_o, 0);
        chk("rst_lo", lo_o, 0);
        chk("rst_stall", stall_o, 0);
        start_i = 1'b1;
        #1;
        chk("rst_stall_start", stall_o, 1);
        start_i = 1'b0;
        #8;
        rst = 1'b1;

        // back-to-back operations
        doOp(32'd100, 32'd7, 1'b0, 33, 32'd14, 32'd2, 1'b0);
        doOp(32'hFFFF_FFF9, 32'd2, 1'b1, 33,
             32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        doOp(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33,
             32'h8000_0000, 32'd0, 1'b0);
        doOp(32'hFFFF_FFFF, 32'd1, 1'b0, 33,
             32'hFFFF_FFFF, 32'd0, 1'b0);

        // start raised during DONE must not launch anything
        start_i = 1'b1;
        opb_i   = 32'd3;
        tick();
        start_i = 1'b0;
        settle();
        chk("done_start_ignored", busy_o, 0);
        chk("hold_lo", lo_o, 32'hFFFF_FFFF);
        chk("hold_hi", hi_o, 32'd0);

        doOp(32'd5, 32'd0, 1'b0, 1, 32'hFFFF_FFFF, 32'd5, 1'b1);

        // cancel mid-CALC
        tick();
        start_i = 1'b1;
        opa_i   = 32'd1000;
        opb_i   = 32'd3;
        settle();
        chk("c_accept_stall", stall_o, 1);
        for (int i = 1; i <= 9; i++) begin
            tick();
            start_i = 1'b0;
            settle();
        end
        tick();
        cancel_i = 1'b1;
        settle();
        chk("c_stall", stall_o, 0);
        chk("c_busy", busy_o, 1);
        tick();
        cancel_i = 1'b0;
        settle();
        chk("c_idle", busy_o, 0);
        for (int i = 0; i < 40; i++) begin
            chk("c_no_done", done_o, 0);
            tick();
            settle();
        end
        chk("c_lo", lo_o, 32'hFFFF_FFFF);
        chk("c_hi", hi_o, 32'd5);
        chk("c_div0", div0_o, 1);

        // cancel in DONE
        tick();
        start_i = 1'b1;
        opa_i   = 32'd20;
        opb_i   = 32'd6;
        settle();
        for (int i = 1; i <= 32; i++) begin
            tick();
            start_i = 1'b0;
            settle();
        end
        tick();
        cancel_i = 1'b1;
        settle();
        chk("cd_done", done_o, 0);
        chk("cd_hilo_we", hilo_we_o, 0);
        chk("cd_stall", stall_o, 0);
        chk("cd_lo", lo_o, 32'd3);
        chk("cd_hi", hi_o, 32'd2);
        chk("cd_div0", div0_o, 0);
        tick();
        cancel_i = 1'b0;
        settle();
        chk("cd_idle", busy_o, 0);
        chk("cd_no_done", done_o, 0);

        // start with cancel in IDLE
        tick();
        start_i  = 1'b1;
        cancel_i = 1'b1;
        settle();
        chk("sc_stall", stall_o, 0);
        tick();
        start_i  = 1'b0;
        cancel_i = 1'b0;
        settle();
        chk("sc_idle", busy_o, 0);

        // reset mid-CALC
        tick();
        start_i = 1'b1;
        opa_i   = 32'd50;
        opb_i   = 32'd5;
        for (int i = 1; i <= 5; i++) begin
            tick();
            start_i = 1'b0;
        end
        settle();
        chk("r_busy_before", busy_o, 1);
        tick();
        rst = 1'b0;
        #1;
        chk("r_busy", busy_o, 0);
        chk("r_stall", stall_o, 0);
        chk("r_done", done_o, 0);
        chk("r_hilo_we", hilo_we_o, 0);
        chk("r_div0", div0_o, 0);
        chk("r_hi", hi_o, 0);
        chk("r_lo", lo_o, 0);
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            settle();
            chk("r_post_busy", busy_o, 0);
            chk("r_post_done", done_o, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
